// File: rtl/regfile_pkg.sv
// Shared definitions for register-file clients: scanner state encodings.
package regfile_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_OFFER = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        OFFER = ST_OFFER,
        DONE  = ST_DONE
    } scan_state_e;

endpackage

// File: rtl/regfile_scanner_if.sv
// Downstream word stream offered by the register-file scanner.
interface regfile_scanner_if #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 8
);
    logic [SIZE-1:0]          out_data;
    logic [$clog2(DEPTH)-1:0] out_addr;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output out_data, output out_addr, output out_valid, input out_ready);
    modport slave  (input out_data, input out_addr, input out_valid, output out_ready);
endinterface

// File: rtl/regfile_scanner.sv
// Walks every register-file entry through one read port, offering each word
// downstream with a valid/ready handshake and accumulating an XOR checksum.
module regfile_scanner
    import regfile_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [$clog2(DEPTH)-1:0] raddr,
    input  logic [SIZE-1:0]          rdata,
    output logic [SIZE-1:0]          out_data,
    output logic [$clog2(DEPTH)-1:0] out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [SIZE-1:0]          checksum
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    scan_state_e   state_r, state_s;
    logic [AW-1:0] ptr_r, ptr_s;
    logic [SIZE-1:0] data_r, data_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [SIZE-1:0] sum_r, sum_s;
    logic          valid_r, busy_r, done_r;

    // State and datapath registers; flags are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= {AW{1'b0}};
            data_r  <= {SIZE{1'b0}};
            addr_r  <= {AW{1'b0}};
            sum_r   <= {SIZE{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            data_r  <= data_s;
            addr_r  <= addr_s;
            sum_r   <= sum_s;
            valid_r <= (state_s == OFFER);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Next-state and datapath update for the scan sequence
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        data_s  = data_r;
        addr_s  = addr_r;
        sum_s   = sum_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    ptr_s   = {AW{1'b0}};
                    sum_s   = {SIZE{1'b0}};
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                // Capturing here keeps the offered word immune to later writes
                data_s  = rdata;
                addr_s  = ptr_r;
                state_s = OFFER;
            end
            OFFER: begin
                if (out_ready) begin
                    sum_s = sum_r ^ data_r;
                    if (ptr_r == LAST_PTR) begin
                        state_s = DONE;
                    end else begin
                        ptr_s   = ptr_r + PTR_ONE;
                        state_s = FETCH;
                    end
                end else begin
                    state_s = OFFER;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign raddr     = ptr_r;
    assign out_data  = data_r;
    assign out_addr  = addr_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign checksum  = sum_r;

endmodule

// File: tb/tb_regfile_scanner.sv
// Self-checking bench: 16x8 and 8x5 scanners against register-file models.
module tb_regfile_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, busy8, done8;
    logic [2:0]  raddr8;
    logic [15:0] rdata8, checksum8;
    logic [15:0] rf8 [8];
    regfile_scanner_if #(.SIZE(16), .DEPTH(8)) bus8 ();
    assign rdata8 = rf8[raddr8];

    regfile_scanner #(.SIZE(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .raddr(raddr8), .rdata(rdata8),
        .out_data(bus8.out_data), .out_addr(bus8.out_addr), .out_valid(bus8.out_valid),
        .out_ready(bus8.out_ready), .busy(busy8), .done(done8), .checksum(checksum8)
    );

    logic       rst5, start5, busy5, done5;
    logic [2:0] raddr5;
    logic [7:0] rdata5, checksum5;
    logic [7:0] rf5 [5];
    regfile_scanner_if #(.SIZE(8), .DEPTH(5)) bus5 ();
    assign rdata5 = (raddr5 < 3'd5) ? rf5[raddr5] : 8'h00;

    regfile_scanner #(.SIZE(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst5), .start(start5), .raddr(raddr5), .rdata(rdata5),
        .out_data(bus5.out_data), .out_addr(bus5.out_addr), .out_valid(bus5.out_valid),
        .out_ready(bus5.out_ready), .busy(busy5), .done(done5), .checksum(checksum5)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full scan of the 8-deep instance against a snapshot of the register file.
    task automatic do_scan(input int rdy_pct, input int hold_addr, input int start_addr,
                           input int abort_addr, input bit keep_start);
        logic [15:0] snap [8];
        logic [15:0] model_sum;
        int idx, cyc, last_acc, holds;
        bit done_seen, aborted, fresh;
        for (int i = 0; i < 8; i++) snap[i] = rf8[i];
        model_sum = 16'h0000;
        idx = 0; cyc = 0; last_acc = 0; holds = 0;
        done_seen = 1'b0; aborted = 1'b0; fresh = 1'b1;
        start8 = 1'b1;
        bus8.out_ready = 1'b0;
        while (!done_seen && !aborted && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!keep_start) start8 = 1'b0;
            bus8.out_ready = 1'b0;
            if (done8) begin
                done_seen = 1'b1;
                check("done_after_last", idx, 8);
                check("done_gap", cyc - last_acc, 1);
                check("done_valid_low", {31'b0, bus8.out_valid}, 0);
                check("checksum_model", {16'b0, checksum8}, {16'b0, model_sum});
            end else if (bus8.out_valid) begin
                check("valid_busy", {31'b0, busy8}, 1);
                if (fresh) begin
                    check("valid_gap", cyc - last_acc, 2);
                    fresh = 1'b0;
                end
                check("out_addr", {29'b0, bus8.out_addr}, idx);
                check("out_data", {16'b0, bus8.out_data}, {16'b0, snap[idx & 7]});
                if (idx == abort_addr) begin
                    rst8 = 1'b1;
                    start8 = 1'b1;
                    aborted = 1'b1;
                end else if (idx == hold_addr && holds < 5) begin
                    if (holds == 0) rf8[hold_addr] = 16'hBEEF;
                    holds++;
                end else begin
                    if (idx == start_addr) start8 = 1'b1;
                    if ($urandom_range(99) < rdy_pct) begin
                        bus8.out_ready = 1'b1;
                        model_sum = model_sum ^ snap[idx & 7];
                        idx++;
                        last_acc = cyc;
                        fresh = 1'b1;
                    end
                end
            end else begin
                check("fetch_busy", {31'b0, busy8}, 1);
                check("fetch_gap", cyc - last_acc, 1);
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst8 = 1'b0;
            start8 = 1'b0;
            check("abort_busy", {31'b0, busy8}, 0);
            check("abort_valid", {31'b0, bus8.out_valid}, 0);
            check("abort_done", {31'b0, done8}, 0);
            check("abort_checksum", {16'b0, checksum8}, 0);
            check("abort_raddr", {29'b0, raddr8}, 0);
            check("abort_out_data", {16'b0, bus8.out_data}, 0);
        end else if (!done_seen) begin
            check("scan_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("idle_busy", {31'b0, busy8}, 0);
            check("idle_done_low", {31'b0, done8}, 0);
            check("idle_checksum", {16'b0, checksum8}, {16'b0, model_sum});
        end
    endtask

    typedef struct {
        logic [7:0][15:0] regs;
        int               rdy_pct;
        int               hold_addr;
        int               start_addr;
        logic [15:0]      exp_sum;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cnt;
        bit got;
        logic [7:0][15:0] ones;
        ones = {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001};
        vecs[0] = '{ones, 100, -1, -1, 16'h00FF};
        vecs[1] = '{ones, 100, 3, -1, 16'h00FF};
        vecs[2] = '{ones, 100, -1, 2, 16'h00FF};
        vecs[3] = '{{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234}, 50, -1, -1, 16'h1234};
        vecs[4] = '{{8{16'hFFFF}}, 70, -1, -1, 16'h0000};
        vecs[5] = '{{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA5A5, 16'h5A5A}, 30, -1, -1, 16'hFFFF};

        for (int i = 0; i < 8; i++) rf8[i] = 16'hFFFF;
        rf5[0] = 8'h11; rf5[1] = 8'h22; rf5[2] = 8'h44; rf5[3] = 8'h88; rf5[4] = 8'hFF;
        rst8 = 1'b1; start8 = 1'b1; bus8.out_ready = 1'b0;
        rst5 = 1'b1; start5 = 1'b0; bus5.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy8}, 0);
        check("rst_valid", {31'b0, bus8.out_valid}, 0);
        check("rst_done", {31'b0, done8}, 0);
        check("rst_checksum", {16'b0, checksum8}, 0);
        check("rst_out_data", {16'b0, bus8.out_data}, 0);
        check("rst_out_addr", {29'b0, bus8.out_addr}, 0);
        check("rst_raddr", {29'b0, raddr8}, 0);
        rst8 = 1'b0; rst5 = 1'b0; start8 = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) rf8[i] = vecs[v].regs[i];
            do_scan(vecs[v].rdy_pct, vecs[v].hold_addr, vecs[v].start_addr, -1, 1'b0);
            check("table_checksum", {16'b0, checksum8}, {16'b0, vecs[v].exp_sum});
            repeat (3) @(negedge clk);
            check("table_checksum_hold", {16'b0, checksum8}, {16'b0, vecs[v].exp_sum});
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) rf8[i] = 16'($urandom);
            do_scan(int'($urandom_range(100, 20)), -1, -1, -1, 1'b0);
        end

        for (int i = 0; i < 8; i++) rf8[i] = ones[i];
        do_scan(100, -1, -1, 5, 1'b0);
        do_scan(100, -1, -1, -1, 1'b0);
        check("rescan_checksum", {16'b0, checksum8}, 32'h00FF);

        do_scan(100, -1, -1, -1, 1'b1);
        @(negedge clk);
        check("held_start_busy", {31'b0, busy8}, 1);
        check("held_start_clear", {16'b0, checksum8}, 0);
        check("held_start_fetch", {31'b0, bus8.out_valid}, 0);
        rst8 = 1'b1; start8 = 1'b0;
        @(negedge clk);
        rst8 = 1'b0;

        start5 = 1'b1; bus5.out_ready = 1'b1;
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            start5 = 1'b0;
            if (done5) begin
                got = 1'b1;
                check("d5_words", cnt, 5);
                check("d5_checksum", {24'b0, checksum5}, 0);
            end else if (bus5.out_valid) begin
                check("d5_addr", {29'b0, bus5.out_addr}, cnt);
                check("d5_data", {24'b0, bus5.out_data}, {24'b0, rf5[cnt % 5]});
                cnt++;
            end
        end
        if (!got) check("d5_timeout", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
